// File: rtl/fifo_reader_buf.sv
// reader_buf: small register FIFO that holds words captured from the
// source FIFO until the downstream stream accepts them.
module reader_buf #(
    parameter int DWID  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DWID-1:0]            push_data,
    input  logic                       pop,
    output logic [DWID-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DWID-1:0] mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   head_d;
    logic [PW-1:0]   tail_q;
    logic [PW-1:0]   tail_d;
    logic [OW-1:0]   occ_q;
    logic [OW-1:0]   occ_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // advance pointers and occupancy for push/pop this cycle
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            tail_d = wrap_inc(tail_q);
        end
        if (pop) begin
            head_d = wrap_inc(head_q);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // data storage is left unreset; occupancy alone says what is live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= push_data;
        end
    end

    assign head_data = (occ_q != '0) ? mem_q[head_q] : '0;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: issues reads to a fixed-latency FIFO and re-presents the
// returned words as a valid/ready stream with a transfer counter.
module fifo_reader #(
    parameter int DWID      = 16,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_enable,
    input  logic            i_empty,
    output logic            o_read,
    input  logic [DWID-1:0] i_dout,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [DWID-1:0] o_data,
    output logic [15:0]     o_words
);

    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int SW = OW + 2;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("fifo_reader: RD_LAT must be in 1..3");
    end

    if (BUF_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("fifo_reader: BUF_DEPTH must be at least RD_LAT+2");
    end

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [15:0]       words_q;
    logic [15:0]       words_d;
    logic [IW-1:0]     inflight;
    logic [OW-1:0]     occ;
    logic [SW-1:0]     pending;
    logic              capture;
    logic              xfer;

    // count reads whose data has not been captured yet
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(vld_q[i]);
        end
    end

    // buffered plus in-flight words must leave room for one more
    assign pending = SW'(occ) + SW'(inflight);
    assign o_read  = rst_n && i_enable && !i_empty
                     && (pending < SW'(BUF_DEPTH));

    // read-valid pipe tracks which cycles carry real FIFO data
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = o_read;
    end

    assign capture = vld_q[RD_LAT-1];
    assign o_valid = (occ != '0);
    assign xfer    = o_valid && i_ready;

    // count completed stream transfers, wrapping naturally
    always_comb begin
        words_d = words_q;
        if (xfer) begin
            words_d = words_q + 16'd1;
        end
    end

    // pipe and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            words_q <= '0;
        end else begin
            vld_q   <= vld_d;
            words_q <= words_d;
        end
    end

    assign o_words = words_q;

    reader_buf #(
        .DWID  (DWID),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (i_dout),
        .pop       (xfer),
        .head_data (o_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: two instances (RD_LAT=1/DEPTH=4 and
// RD_LAT=3/DEPTH=5) checked every cycle against a queue-based model.
module tb_fifo_reader;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       en;
    logic [1:0]       empty;
    logic [1:0]       rdy;
    logic [1:0]       rd;
    logic [1:0]       vld;
    logic [1:0][15:0] dout;
    logic [1:0][15:0] data;
    logic [1:0][15:0] words;

    always #5 clk = ~clk;

    fifo_reader #(.DWID(16), .RD_LAT(1), .BUF_DEPTH(4)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (en[0]),
        .i_empty  (empty[0]),
        .o_read   (rd[0]),
        .i_dout   (dout[0]),
        .o_valid  (vld[0]),
        .i_ready  (rdy[0]),
        .o_data   (data[0]),
        .o_words  (words[0])
    );

    fifo_reader #(.DWID(16), .RD_LAT(3), .BUF_DEPTH(5)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (en[1]),
        .i_empty  (empty[1]),
        .o_read   (rd[1]),
        .i_dout   (dout[1]),
        .o_valid  (vld[1]),
        .i_ready  (rdy[1]),
        .o_data   (data[1]),
        .o_words  (words[1])
    );

    // model state: source FIFO, words in flight, output buffer
    logic [15:0] src     [2][$];
    logic [15:0] obuf    [2][$];
    logic [15:0] fly_w   [2][$];
    int          fly_due [2][$];
    logic [15:0] xlog    [2][$];
    int          xcyc    [2][$];
    int          rcyc    [2][$];
    int          exp_words [2];

    logic             rst_v;
    logic [1:0]       en_v;
    logic [1:0]       rdy_v;
    logic [1:0]       tog_v;
    logic [1:0][15:0] dout_v;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start;

    function automatic int lat(input int c);
        return (c == 0) ? 1 : 3;
    endfunction

    function automatic int depth(input int c);
        return (c == 0) ? 4 : 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int c);
        logic        e_rd;
        logic        e_vld;
        logic [15:0] e_dat;
        string       p;
        p = $sformatf("ch%0d", c);
        if (!rst_n) begin
            chk({p, " rst o_read"},  32'(rd[c]),    32'h0);
            chk({p, " rst o_valid"}, 32'(vld[c]),   32'h0);
            chk({p, " rst o_data"},  32'(data[c]),  32'h0);
            chk({p, " rst o_words"}, 32'(words[c]), 32'h0);
            obuf[c].delete();
            fly_w[c].delete();
            fly_due[c].delete();
            exp_words[c] = 0;
            dout_v[c] = 16'($urandom);
            return;
        end
        e_rd  = en[c] && !empty[c]
                && (obuf[c].size() + fly_w[c].size() < depth(c));
        e_vld = (obuf[c].size() != 0);
        e_dat = e_vld ? obuf[c][0] : 16'h0;
        chk({p, " o_read"},  32'(rd[c]),  32'(e_rd));
        chk({p, " o_valid"}, 32'(vld[c]), 32'(e_vld));
        if (e_vld) begin
            chk({p, " o_data"}, 32'(data[c]), 32'(e_dat));
        end
        chk({p, " o_words"}, 32'(words[c]), 32'(16'(exp_words[c])));
        if (e_rd) begin
            rcyc[c].push_back(cyc);
        end
        if (e_vld && rdy[c]) begin
            xlog[c].push_back(obuf[c][0]);
            xcyc[c].push_back(cyc);
            void'(obuf[c].pop_front());
            exp_words[c]++;
        end
        for (int i = 0; i < fly_due[c].size(); i++) begin
            fly_due[c][i] = fly_due[c][i] - 1;
        end
        if (fly_w[c].size() != 0 && fly_due[c][0] == 0) begin
            obuf[c].push_back(fly_w[c][0]);
            void'(fly_w[c].pop_front());
            void'(fly_due[c].pop_front());
        end
        if (e_rd && src[c].size() != 0) begin
            fly_w[c].push_back(src[c].pop_front());
            fly_due[c].push_back(lat(c));
        end
        if (fly_w[c].size() != 0 && fly_due[c][0] == 1) begin
            dout_v[c] = fly_w[c][0];
        end else begin
            dout_v[c] = 16'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (tog_v[c]) begin
                rdy_v[c] = ~rdy_v[c];
            end
        end
        rst_n = rst_v;
        en    = en_v;
        rdy   = rdy_v;
        for (int c = 0; c < 2; c++) begin
            empty[c] = (src[c].size() == 0);
            dout[c]  = dout_v[c];
        end
        @(negedge clk);
        model_step(0);
        model_step(1);
    endtask

    task automatic clear_logs(input int c);
        xlog[c].delete();
        xcyc[c].delete();
        rcyc[c].delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 2'b00;
        empty  = 2'b11;
        rdy    = 2'b00;
        dout   = '0;
        rst_v  = 1'b0;
        en_v   = 2'b00;
        rdy_v  = 2'b00;
        tog_v  = 2'b00;
        dout_v = '0;
        exp_words[0] = 0;
        exp_words[1] = 0;
        repeat (3) cycle();

        // idle: enabled but source empty
        rst_v = 1'b1;
        en_v  = 2'b11;
        repeat (6) cycle();
        chk("idle words0", 32'(words[0]), 32'h0);
        chk("idle valid",  32'(vld), 32'h0);
        chk("idle reads",  32'(rcyc[0].size() + rcyc[1].size()), 32'd0);

        // streaming with ready held high
        clear_logs(0);
        for (int i = 1; i <= 8; i++) src[0].push_back(16'(i));
        rdy_v[0] = 1'b1;
        start = cyc + 1;
        repeat (14) cycle();
        chk("s1 first read",  32'(rcyc[0][0]), 32'(start));
        chk("s1 first xfer",  32'(xcyc[0][0]), 32'(start + 2));
        chk("s1 xfer count",  32'(xcyc[0].size()), 32'd8);
        chk("s1 last xfer",   32'(xcyc[0][7]), 32'(start + 9));
        for (int i = 0; i < 8; i++) begin
            chk("s1 order", 32'(xlog[0][i]), 32'(i + 1));
        end
        chk("s1 words", 32'(words[0]), 32'd8);

        // stalled downstream fills the buffer then drains in order
        clear_logs(0);
        rdy_v[0] = 1'b0;
        for (int i = 1; i <= 8; i++) src[0].push_back(16'(i));
        repeat (8) cycle();
        chk("s2 reads",  32'(rcyc[0].size()), 32'd4);
        chk("s2 valid",  32'(vld[0]), 32'h1);
        chk("s2 head",   32'(data[0]), 32'h0001);
        chk("s2 words",  32'(words[0]), 32'd8);
        rdy_v[0] = 1'b1;
        repeat (14) cycle();
        chk("s2 xfer count", 32'(xlog[0].size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("s2 order", 32'(xlog[0][i]), 32'(i + 1));
        end
        chk("s2 words end", 32'(words[0]), 32'd16);

        // long latency with ready toggling every cycle
        clear_logs(1);
        for (int i = 1; i <= 12; i++) src[1].push_back(16'(16'h0100 + i));
        rdy_v[1] = 1'b0;
        tog_v[1] = 1'b1;
        repeat (40) cycle();
        tog_v[1] = 1'b0;
        chk("s3 xfer count", 32'(xlog[1].size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("s3 order", 32'(xlog[1][i]), 32'(16'h0100 + i + 1));
        end
        for (int i = 1; i < 12; i++) begin
            chk("s3 spacing", 32'(xcyc[1][i] - xcyc[1][i-1]), 32'd2);
        end
        chk("s3 words", 32'(words[1]), 32'd12);

        // enable dropped with one read in flight
        clear_logs(0);
        src[0].push_back(16'h0AA1);
        src[0].push_back(16'h0AA2);
        src[0].push_back(16'h0AA3);
        en_v[0]  = 1'b1;
        rdy_v[0] = 1'b1;
        cycle();
        en_v[0] = 1'b0;
        repeat (6) cycle();
        chk("s4 reads",     32'(rcyc[0].size()), 32'd1);
        chk("s4 xfers",     32'(xlog[0].size()), 32'd1);
        chk("s4 word",      32'(xlog[0][0]), 32'h0AA1);
        chk("s4 words",     32'(words[0]), 32'd17);
        chk("s4 src left",  32'(src[0].size()), 32'd2);
        src[0].delete();

        // reset with three buffered words
        clear_logs(0);
        rdy_v[0] = 1'b0;
        en_v[0]  = 1'b1;
        src[0].push_back(16'h0B01);
        src[0].push_back(16'h0B02);
        src[0].push_back(16'h0B03);
        repeat (5) cycle();
        chk("s5 valid pre",  32'(vld[0]), 32'h1);
        chk("s5 head pre",   32'(data[0]), 32'h0B01);
        rst_v = 1'b0;
        cycle();
        chk("s5 valid rst",  32'(vld[0]), 32'h0);
        chk("s5 words rst",  32'(words[0]), 32'h0);
        rst_v = 1'b1;
        clear_logs(0);
        src[0].push_back(16'h0C01);
        src[0].push_back(16'h0C02);
        rdy_v[0] = 1'b1;
        repeat (8) cycle();
        chk("s5 xfers",  32'(xlog[0].size()), 32'd2);
        chk("s5 first",  32'(xlog[0][0]), 32'h0C01);
        chk("s5 second", 32'(xlog[0][1]), 32'h0C02);
        chk("s5 words",  32'(words[0]), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DWID, default 16, data word width in bits.
REQ-002 Parameter RD_LAT, default 1, cycles from o_read high to read data valid on i_dout (legal 1..3).
REQ-003 Parameter BUF_DEPTH, default 4, output buffer entries; SHALL satisfy BUF_DEPTH >= RD_LAT+2, with an elaboration error otherwise.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_enable  input  1  high permits new FIFO reads; low stops issuing but drains in-flight data.
REQ-007 i_empty  input  1  FIFO empty flag.
REQ-008 o_read  output  1  FIFO read strobe, one word per cycle high.
REQ-009 i_dout  input  DWID  FIFO read data, valid RD_LAT cycles after the matching o_read.
REQ-010 o_valid  output  1  stream data valid.
REQ-011 i_ready  input  1  downstream accept; transfer = o_valid && i_ready.
REQ-012 o_data  output  DWID  stream data, head of output buffer.
REQ-013 o_words  output  16  count of completed stream transfers, wraps 0xFFFF->0.

Function
REQ-014 o_read SHALL be high iff i_enable && !i_empty && (occupancy + inflight) < BUF_DEPTH, all sampled in the current cycle; o_read is combinational from these terms.
REQ-015 inflight SHALL be the number of reads issued whose data has not yet been captured (0..RD_LAT), tracked by an RD_LAT-deep valid shift register.
REQ-016 When the last stage of the valid shift register is set, i_dout SHALL be written into the buffer tail that cycle; data from cycles without an issued read SHALL never be captured.
REQ-017 Buffer SHALL be first-in first-out; o_valid = (occupancy != 0); o_data = head entry; o_data SHALL hold stable while o_valid && !i_ready.
REQ-018 Simultaneous capture and transfer SHALL leave occupancy unchanged; head and tail pointers SHALL wrap modulo BUF_DEPTH.
REQ-019 Capture SHALL never occur at occupancy == BUF_DEPTH (guaranteed by REQ-014); a freed entry is visible to REQ-014 the cycle after the transfer.
REQ-020 With i_ready held high, i_enable high and FIFO non-empty, sustained throughput SHALL be one word per cycle after a fill latency of RD_LAT+1 cycles from first o_read to first o_valid.
REQ-021 i_enable falling SHALL stop o_read the same cycle; in-flight words SHALL still be captured and presented.
REQ-022 o_words SHALL increment by 1 on each transfer cycle.
REQ-023 i_empty high with reads in flight SHALL not cancel them.

Reset
REQ-024 rst_n low SHALL asynchronously clear occupancy, pointers, valid shift register and o_words; o_valid=0, o_read=0, o_data=0.
REQ-025 Reset mid-transfer SHALL discard buffered and in-flight words; the first capture after release SHALL only follow a post-reset o_read.
REQ-026 Buffer data storage need not be reset.

Structure
REQ-027 No shared package; buffer pointer width SHALL be a localparam $clog2(BUF_DEPTH), occupancy width $clog2(BUF_DEPTH+1).
REQ-028 One sub-module SHALL be used: reader_buf (BUF_DEPTH x DWID register FIFO with push, pop, occupancy); latency pipe lives in fifo_reader.

Verification
REQ-029 Reset release, i_empty=1, i_enable=1 -> o_read=0, o_valid=0, o_words=0 indefinitely.
REQ-030 RD_LAT=1, FIFO holds 0x0001..0x0008, i_ready=1 -> o_read first cycle, o_valid 2 cycles later, 8 consecutive transfers in order, o_words=8.
REQ-031 Same stimulus, i_ready=0 -> exactly 4 o_read pulses, o_valid=1 with o_data=0x0001 held; i_ready raised -> remaining 4 words follow in order.
REQ-032 RD_LAT=3, BUF_DEPTH=5, i_ready toggling every cycle -> no loss, no duplicate, 1 transfer per 2 cycles, order preserved.
REQ-033 i_enable dropped with 1 read in flight -> that word delivered, no further o_read.
REQ-034 rst_n pulsed low with 3 buffered words -> o_valid=0 immediately, o_words=0, next delivered word is first word read after release.
